mem_stage: RTL and testbench

//  Memory-access stage directly downstream of the ALU. Registers the ALU result

---
 rtl/mem_stage.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage: memory-access stage downstream of the ALU.
//
// Registers the ALU result and store data, then performs a load/store on a
// req/ack data-memory port. Byte/halfword accesses are steered onto
// little-endian lanes. Loads are sign- or zero-extended. Every instruction
// retires with a one-cycle wb_valid_o pulse. ex_ready_o is low while a memory
// access is outstanding.
//
// Configuration macro: MEM_MISALIGN_TRAP_EN
//   defined   : adds exc_misalign_o. Misaligned ops issue no request and
//               retire next cycle with exc_misalign_o=1 and the faulting
//               address on wb_data_o.
//   undefined : misaligned ops are force-aligned and proceed normally.
//
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   ex_valid_i/ex_ready_o    execute-stage handshake
//   ex_result_i              ALU result (address or passthrough data)
//   ex_store_data_i          store data
//   ex_mem_op_i              0 NONE,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 SB,7 SH,8 SW
//   ex_rd_i, ex_reg_write_i  destination register and its write qualifier
//   dmem_req_o .. dmem_be_o  memory request, held until dmem_ack_i
//   dmem_ack_i, dmem_rdata_i memory completion and read data
//   wb_valid_o .. wb_reg_write_o  writeback pulse and payload
//   exc_misalign_o           misalignment trap flag (MEM_MISALIGN_TRAP_EN only)
// -----------------------------------------------------------------------------
module mem_stage #(
   parameter int unsigned WORD_SIZE = 32,
   parameter int unsigned ADDR_SIZE = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 ex_valid_i,
   output logic                 ex_ready_o,
   input  logic [WORD_SIZE-1:0] ex_result_i,
   input  logic [WORD_SIZE-1:0] ex_store_data_i,
   input  logic [3:0]           ex_mem_op_i,
   input  logic [4:0]           ex_rd_i,
   input  logic                 ex_reg_write_i,
   output logic                 dmem_req_o,
   output logic                 dmem_we_o,
   output logic [ADDR_SIZE-1:0] dmem_addr_o,
   output logic [31:0]          dmem_wdata_o,
   output logic [3:0]           dmem_be_o,
   input  logic                 dmem_ack_i,
   input  logic [31:0]          dmem_rdata_i,
   output logic                 wb_valid_o,
   output logic [WORD_SIZE-1:0] wb_data_o,
   output logic [4:0]           wb_rd_o,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic                 wb_reg_write_o,
   output logic                 exc_misalign_o
`else
   output logic                 wb_reg_write_o
`endif
);

   if (WORD_SIZE != 32) begin : gen_bad_word
      $error("mem_stage: only WORD_SIZE == 32 is supported");
   end
   if (ADDR_SIZE < 3 || ADDR_SIZE > WORD_SIZE) begin : gen_bad_addr
      $error("mem_stage: ADDR_SIZE must be in 3..WORD_SIZE");
   end

   localparam logic [3:0] OpLb  = 4'd1;
   localparam logic [3:0] OpLbu = 4'd2;
   localparam logic [3:0] OpLh  = 4'd3;
   localparam logic [3:0] OpLhu = 4'd4;
   localparam logic [3:0] OpLw  = 4'd5;
   localparam logic [3:0] OpSb  = 4'd6;
   localparam logic [3:0] OpSh  = 4'd7;
   localparam logic [3:0] OpSw  = 4'd8;

   typedef enum logic [0:0] {StIdle, StReq} state_e;

   state_e                 state_q, state_d;
   logic                   req_q, req_d;
   logic                   we_q, we_d;
   logic [ADDR_SIZE-1:0]   addr_q, addr_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [3:0]             be_q, be_d;
   logic [3:0]             op_q, op_d;
   logic [1:0]             off_q, off_d;
   logic [4:0]             rd_q, rd_d;
   logic                   rw_q, rw_d;
   logic                   wb_valid_q, wb_valid_d;
   logic [WORD_SIZE-1:0]   wb_data_q, wb_data_d;
   logic [4:0]             wb_rd_q, wb_rd_d;
   logic                   wb_rw_q, wb_rw_d;
   logic                   exc_q, exc_d;

   logic       is_load, is_store, is_mem, trap;
   logic [1:0] lane_off;
   logic [3:0] st_be;
   logic [31:0] st_wdata;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   assign is_load  = (ex_mem_op_i >= OpLb) && (ex_mem_op_i <= OpLw);
   assign is_store = (ex_mem_op_i >= OpSb) && (ex_mem_op_i <= OpSw);
   assign is_mem   = is_load | is_store;

`ifdef MEM_MISALIGN_TRAP_EN
   logic misalign;
   always_comb begin
      unique case (ex_mem_op_i)
         OpLh, OpLhu, OpSh: misalign = ex_result_i[0];
         OpLw, OpSw:        misalign = (ex_result_i[1:0] != 2'b00);
         default:           misalign = 1'b0;
      endcase
   end
   assign trap = is_mem & misalign;
`else
   assign trap = 1'b0;
`endif

   // Lane offset with the force-align rule built in: halves drop addr[0],
   // words drop both low bits.
   always_comb begin
      unique case (ex_mem_op_i)
         OpLb, OpLbu, OpSb: lane_off = ex_result_i[1:0];
         OpLh, OpLhu, OpSh: lane_off = {ex_result_i[1], 1'b0};
         default:           lane_off = 2'b00;
      endcase
   end

   always_comb begin
      unique case (ex_mem_op_i)
         OpSb: begin
            st_be    = 4'b0001 << lane_off;
            st_wdata = {4{ex_store_data_i[7:0]}};
         end
         OpSh: begin
            st_be    = lane_off[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{ex_store_data_i[15:0]}};
         end
         OpSw: begin
            st_be    = 4'b1111;
            st_wdata = ex_store_data_i[31:0];
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = 32'd0;
         end
      endcase
   end

   assign ld_byte = dmem_rdata_i[{off_q, 3'b000} +: 8];
   assign ld_half = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

   always_comb begin
      unique case (op_q)
         OpLb:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         OpLbu:   ld_data = {24'd0, ld_byte};
         OpLh:    ld_data = {{16{ld_half[15]}}, ld_half};
         OpLhu:   ld_data = {16'd0, ld_half};
         default: ld_data = dmem_rdata_i;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      op_d       = op_q;
      off_d      = off_q;
      rd_d       = rd_q;
      rw_d       = rw_q;
      wb_valid_d = 1'b0;
      wb_data_d  = wb_data_q;
      wb_rd_d    = wb_rd_q;
      wb_rw_d    = wb_rw_q;
      exc_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ex_valid_i) begin
               if (trap) begin
                  wb_valid_d = 1'b1;
                  exc_d      = 1'b1;
                  wb_data_d  = ex_result_i;
                  wb_rd_d    = ex_rd_i;
                  wb_rw_d    = 1'b0;
               end else if (is_mem) begin
                  state_d = StReq;
                  req_d   = 1'b1;
                  we_d    = is_store;
                  addr_d  = {ex_result_i[ADDR_SIZE-1:2], 2'b00};
                  wdata_d = st_wdata;
                  be_d    = st_be;
                  op_d    = ex_mem_op_i;
                  off_d   = lane_off;
                  rd_d    = ex_rd_i;
                  rw_d    = ex_reg_write_i;
               end else begin
                  // NONE and undefined opcodes pass the ALU result through.
                  wb_valid_d = 1'b1;
                  wb_data_d  = ex_result_i;
                  wb_rd_d    = ex_rd_i;
                  wb_rw_d    = ex_reg_write_i;
               end
            end
         end
         StReq: begin
            if (dmem_ack_i) begin
               state_d    = StIdle;
               req_d      = 1'b0;
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               if (we_q) begin
                  wb_data_d = '0;
                  wb_rw_d   = 1'b0;
               end else begin
                  wb_data_d = ld_data;
                  wb_rw_d   = rw_q;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         op_q       <= '0;
         off_q      <= '0;
         rd_q       <= '0;
         rw_q       <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
         wb_rw_q    <= 1'b0;
         exc_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         op_q       <= op_d;
         off_q      <= off_d;
         rd_q       <= rd_d;
         rw_q       <= rw_d;
         wb_valid_q <= wb_valid_d;
         wb_data_q  <= wb_data_d;
         wb_rd_q    <= wb_rd_d;
         wb_rw_q    <= wb_rw_d;
         exc_q      <= exc_d;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (rst_ni && ex_valid_i && (state_q == StIdle) && (ex_mem_op_i > OpSw)) begin
         $warning("mem_stage: undefined ex_mem_op %0d treated as NONE", ex_mem_op_i);
      end
   end
`endif

   assign ex_ready_o     = (state_q == StIdle);
   assign dmem_req_o     = req_q;
   assign dmem_we_o      = we_q;
   assign dmem_addr_o    = addr_q;
   assign dmem_wdata_o   = wdata_q;
   assign dmem_be_o      = be_q;
   assign wb_valid_o     = wb_valid_q;
   assign wb_data_o      = wb_data_q;
   assign wb_rd_o        = wb_rd_q;
   assign wb_reg_write_o = wb_rw_q;
`ifdef MEM_MISALIGN_TRAP_EN
   assign exc_misalign_o = exc_q;
`else
   // exc_q is constant zero in this build; keep it referenced.
   logic unused_exc;
   assign unused_exc = exc_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage: self-checking bench for mem_stage. Expected writebacks are
// queued when an instruction is issued; a monitor pops and compares on every
// wb_valid_o pulse. Memory-port and handshake signals are checked inline.
// -----------------------------------------------------------------------------
module tb_mem_stage;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        ex_valid_i;
   logic        ex_ready_o;
   logic [31:0] ex_result_i;
   logic [31:0] ex_store_data_i;
   logic [3:0]  ex_mem_op_i;
   logic [4:0]  ex_rd_i;
   logic        ex_reg_write_i;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_ack_i;
   logic [31:0] dmem_rdata_i;
   logic        wb_valid_o;
   logic [31:0] wb_data_o;
   logic [4:0]  wb_rd_o;
   logic        wb_reg_write_o;
   logic        exc_misalign_o;

   mem_stage #(.WORD_SIZE(32), .ADDR_SIZE(32)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .ex_valid_i      (ex_valid_i),
      .ex_ready_o      (ex_ready_o),
      .ex_result_i     (ex_result_i),
      .ex_store_data_i (ex_store_data_i),
      .ex_mem_op_i     (ex_mem_op_i),
      .ex_rd_i         (ex_rd_i),
      .ex_reg_write_i  (ex_reg_write_i),
      .dmem_req_o      (dmem_req_o),
      .dmem_we_o       (dmem_we_o),
      .dmem_addr_o     (dmem_addr_o),
      .dmem_wdata_o    (dmem_wdata_o),
      .dmem_be_o       (dmem_be_o),
      .dmem_ack_i      (dmem_ack_i),
      .dmem_rdata_i    (dmem_rdata_i),
      .wb_valid_o      (wb_valid_o),
      .wb_data_o       (wb_data_o),
      .wb_rd_o         (wb_rd_o),
`ifdef MEM_MISALIGN_TRAP_EN
      .wb_reg_write_o  (wb_reg_write_o),
      .exc_misalign_o  (exc_misalign_o)
`else
      .wb_reg_write_o  (wb_reg_write_o)
`endif
   );

`ifndef MEM_MISALIGN_TRAP_EN
   assign exc_misalign_o = 1'b0;
`endif

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        rw;
      logic        exc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk_i) begin
      if (wb_valid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wb_unexpected: got wb_data 0x%08h, expected no writeback", wb_data_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("wb_data", wb_data_o, e.data);
            check("wb_rd", {27'd0, wb_rd_o}, {27'd0, e.rd});
            check("wb_reg_write", {31'd0, wb_reg_write_o}, {31'd0, e.rw});
            check("exc_misalign", {31'd0, exc_misalign_o}, {31'd0, e.exc});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Issue one op on the current cycle; caller is at posedge+1.
   task automatic issue(input logic [3:0] op, input logic [31:0] res, input logic [31:0] sd,
                        input logic [4:0] rd, input logic rw);
      ex_valid_i      = 1'b1;
      ex_mem_op_i     = op;
      ex_result_i     = res;
      ex_store_data_i = sd;
      ex_rd_i         = rd;
      ex_reg_write_i  = rw;
   endtask

   // Full memory operation with a fixed number of wait cycles before ack.
   task automatic mem_op(input string nm, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                         input int waits, input logic [31:0] rdata,
                         input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_be,
                         input logic [31:0] e_wdata, input logic [31:0] e_data,
                         input logic e_rw);
      exp_t e;
      check({nm, "_ready_before"}, {31'd0, ex_ready_o}, 32'd1);
      issue(op, addr, sd, rd, rw);
      e.data = e_data; e.rd = rd; e.rw = e_rw; e.exc = 1'b0;
      exp_q.push_back(e);
      step();
      ex_valid_i = 1'b0;
      check({nm, "_req"}, {31'd0, dmem_req_o}, 32'd1);
      check({nm, "_we"}, {31'd0, dmem_we_o}, {31'd0, e_we});
      check({nm, "_addr"}, dmem_addr_o, e_addr);
      check({nm, "_be"}, {28'd0, dmem_be_o}, {28'd0, e_be});
      if (e_we) check({nm, "_wdata"}, dmem_wdata_o, e_wdata);
      for (int i = 0; i < waits; i++) begin
         check({nm, "_ready_wait"}, {31'd0, ex_ready_o}, 32'd0);
         step();
         check({nm, "_req_held"}, {31'd0, dmem_req_o}, 32'd1);
         check({nm, "_addr_held"}, dmem_addr_o, e_addr);
      end
      check({nm, "_ready_req"}, {31'd0, ex_ready_o}, 32'd0);
      dmem_ack_i   = 1'b1;
      dmem_rdata_i = rdata;
      step();
      dmem_ack_i   = 1'b0;
      dmem_rdata_i = 32'hXXXX_XXXX;
      check({nm, "_req_drop"}, {31'd0, dmem_req_o}, 32'd0);
      check({nm, "_wb_pulse"}, {31'd0, wb_valid_o}, 32'd1);
      check({nm, "_ready_after"}, {31'd0, ex_ready_o}, 32'd1);
      step();
   endtask

   initial begin
      rst_ni          = 1'b0;
      dmem_ack_i      = 1'b1;
      dmem_rdata_i    = 32'h0;
      issue(4'd0, 32'h55, 32'h0, 5'd1, 1'b1);
      step();
      step();
      check("rst_req", {31'd0, dmem_req_o}, 32'd0);
      check("rst_we", {31'd0, dmem_we_o}, 32'd0);
      check("rst_addr", dmem_addr_o, 32'd0);
      check("rst_wdata", dmem_wdata_o, 32'd0);
      check("rst_be", {28'd0, dmem_be_o}, 32'd0);
      check("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
      check("rst_wb_data", wb_data_o, 32'd0);
      ex_valid_i = 1'b0;
      dmem_ack_i = 1'b0;
      rst_ni     = 1'b1;
      step();
      check("rst_ready", {31'd0, ex_ready_o}, 32'd1);
      check("rst_no_wb", {31'd0, wb_valid_o}, 32'd0);

      // Three back-to-back NONE ops
      for (int i = 1; i <= 3; i++) begin
         exp_t e;
         check("none_ready", {31'd0, ex_ready_o}, 32'd1);
         issue(4'd0, i, 32'h0, 5'(i + 3), 1'b1);
         e.data = i; e.rd = 5'(i + 3); e.rw = 1'b1; e.exc = 1'b0;
         exp_q.push_back(e);
         step();
         check("none_wb_valid", {31'd0, wb_valid_o}, 32'd1);
      end
      ex_valid_i = 1'b0;
      step();
      check("none_wb_end", {31'd0, wb_valid_o}, 32'd0);

      // Loads: lane steering and extension
      mem_op("lb",  4'd1, 32'h1003, 32'h0, 5'd5, 1'b1, 3, 32'h8011_2233,
             32'h1000, 1'b0, 4'b1111, 32'h0, 32'hFFFF_FF80, 1'b1);
      mem_op("lbu", 4'd2, 32'h1003, 32'h0, 5'd6, 1'b1, 3, 32'h8011_2233,
             32'h1000, 1'b0, 4'b1111, 32'h0, 32'h0000_0080, 1'b1);
      mem_op("lb1", 4'd1, 32'h1001, 32'h0, 5'd7, 1'b1, 0, 32'h8011_2233,
             32'h1000, 1'b0, 4'b1111, 32'h0, 32'h0000_0022, 1'b1);
      mem_op("lh",  4'd3, 32'h4002, 32'h0, 5'd8, 1'b1, 1, 32'h8001_7FFF,
             32'h4000, 1'b0, 4'b1111, 32'h0, 32'hFFFF_8001, 1'b1);
      mem_op("lhu", 4'd4, 32'h4002, 32'h0, 5'd9, 1'b1, 0, 32'h8001_7FFF,
             32'h4000, 1'b0, 4'b1111, 32'h0, 32'h0000_8001, 1'b1);
      mem_op("lh0", 4'd3, 32'h4000, 32'h0, 5'd10, 1'b1, 0, 32'h8001_7FFF,
             32'h4000, 1'b0, 4'b1111, 32'h0, 32'h0000_7FFF, 1'b1);
      mem_op("lw",  4'd5, 32'h5000, 32'h0, 5'd11, 1'b1, 2, 32'h1234_5678,
             32'h5000, 1'b0, 4'b1111, 32'h0, 32'h1234_5678, 1'b1);

      // Stores retire with wb_reg_write=0 and wb_data=0
      mem_op("sh", 4'd7, 32'h2002, 32'hDEAD_BEEF, 5'd0, 1'b0, 0, 32'h0,
             32'h2000, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0);
      mem_op("sb", 4'd6, 32'h6001, 32'h0000_00A5, 5'd0, 1'b0, 1, 32'h0,
             32'h6000, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0);
      mem_op("sw", 4'd8, 32'h7000, 32'hCAFE_F00D, 5'd0, 1'b0, 0, 32'h0,
             32'h7000, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0);

      // Reset while in REQ abandons the access
      issue(4'd5, 32'h3000, 32'h0, 5'd12, 1'b1);
      step();
      ex_valid_i = 1'b0;
      check("rstreq_req", {31'd0, dmem_req_o}, 32'd1);
      rst_ni = 1'b0;
      step();
      check("rstreq_req_drop", {31'd0, dmem_req_o}, 32'd0);
      check("rstreq_ready", {31'd0, ex_ready_o}, 32'd1);
      rst_ni       = 1'b1;
      dmem_ack_i   = 1'b1;
      dmem_rdata_i = 32'hFFFF_FFFF;
      step();
      dmem_ack_i = 1'b0;
      check("rstreq_late_ack_req", {31'd0, dmem_req_o}, 32'd0);
      check("rstreq_no_wb", {31'd0, wb_valid_o}, 32'd0);
      step();
      check("rstreq_idle", {31'd0, ex_ready_o}, 32'd1);

      // Undefined opcode behaves as NONE
      begin
         exp_t e;
         issue(4'd11, 32'h0000_0099, 32'h0, 5'd13, 1'b1);
         e.data = 32'h99; e.rd = 5'd13; e.rw = 1'b1; e.exc = 1'b0;
         exp_q.push_back(e);
         step();
         ex_valid_i = 1'b0;
         check("badop_no_req", {31'd0, dmem_req_o}, 32'd0);
         step();
      end

      // Misaligned word load
`ifdef MEM_MISALIGN_TRAP_EN
      begin
         exp_t e;
         issue(4'd5, 32'h3001, 32'h0, 5'd14, 1'b1);
         e.data = 32'h3001; e.rd = 5'd14; e.rw = 1'b0; e.exc = 1'b1;
         exp_q.push_back(e);
         step();
         ex_valid_i = 1'b0;
         check("mis_no_req", {31'd0, dmem_req_o}, 32'd0);
         check("mis_wb", {31'd0, wb_valid_o}, 32'd1);
         check("mis_ready", {31'd0, ex_ready_o}, 32'd1);
         step();
      end
`else
      mem_op("mis_lw", 4'd5, 32'h3001, 32'h0, 5'd14, 1'b1, 0, 32'hA1B2_C3D4,
             32'h3000, 1'b0, 4'b1111, 32'h0, 32'hA1B2_C3D4, 1'b1);
`endif

      step();
      step();
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
